// File: rtl/mash_stage1_accum.sv
// ---------------------------------------------------------------------------
// mash_stage1_accum
// First-order accumulator stage of a MASH 1-1 sigma-delta DAC modulator.
// Each accepted signed sample is mapped to offset binary and added to the
// accumulator. The overflow bit is the coarse 1-bit output. The accumulator
// value, mapped back to two's complement, is the residue for stage two.
// Optional LFSR dither feeds the carry-in. A carry-density monitor reports
// the number of carries in each window of 2**WIN_LOG2 accepted samples.
//
// Ports
//   i_clck        clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_clr         synchronous clear; takes priority over i_en
//   i_en          sample strobe; i_x is accepted on the edge when high
//   i_x           signed two's-complement input sample
//   o_c_out       accumulator carry (coarse output)
//   o_e_out       signed residue (accumulator with MSB inverted)
//   o_out_valid   1-cycle pulse: o_c_out/o_e_out updated
//   o_density     carry count of the last complete window
//   o_dens_valid  1-cycle pulse: o_density updated
// ---------------------------------------------------------------------------
module mash_stage1_accum #(
    parameter int          WIDTH     = 4,
    parameter bit          DITHER_EN = 1'b0,
    parameter logic [7:0]  LFSR_SEED = 8'hA5,
    parameter int          WIN_LOG2  = 4
) (
    input  logic                i_clck,
    input  logic                i_rst,
    input  logic                i_clr,
    input  logic                i_en,
    input  logic [WIDTH-1:0]    i_x,
    output logic                o_c_out,
    output logic [WIDTH-1:0]    o_e_out,
    output logic                o_out_valid,
    output logic [WIN_LOG2:0]   o_density,
    output logic                o_dens_valid
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Fibonacci LFSR, taps 8,6,5,4; new bit enters at the LSB.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Two's complement <-> offset binary is the same MSB inversion both ways.
    function automatic logic [WIDTH-1:0] msb_flip(input logic [WIDTH-1:0] v);
        return {~v[WIDTH-1], v[WIDTH-2:0]};
    endfunction

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_acc;
    logic [7:0]             r_lfsr;
    logic [WIN_LOG2-1:0]    r_win_cnt;
    logic [WIN_LOG2:0]      r_carry_cnt;

    logic                   w_accept;
    logic                   w_dither;
    logic [WIDTH:0]         w_sum;
    logic                   w_win_last;
    logic [WIN_LOG2:0]      w_carry_ext;

    assign w_accept    = i_en & ~i_clr;
    assign w_dither    = DITHER_EN ? r_lfsr[0] : 1'b0;
    // Sum in WIDTH+1 bits: the bit lost by the modulo wrap is the carry.
    assign w_sum       = {1'b0, r_acc} + {1'b0, msb_flip(i_x)}
                       + {{WIDTH{1'b0}}, w_dither};
    assign w_win_last  = (r_win_cnt == {WIN_LOG2{1'b1}});
    assign w_carry_ext = {{WIN_LOG2{1'b0}}, w_sum[WIDTH]};

    // FSM state register.
    always_ff @(posedge i_clck or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: leave IDLE on the first accepted sample, return only on clear.
    always_comb begin
        w_state_nxt = r_state;
        if (i_clr) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_RUN:  w_state_nxt = ST_RUN;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Accumulator, dither LFSR and registered sample outputs.
    always_ff @(posedge i_clck or posedge i_rst) begin
        if (i_rst) begin
            r_acc       <= {WIDTH{1'b0}};
            r_lfsr      <= LFSR_SEED;
            o_c_out     <= 1'b0;
            o_e_out     <= {WIDTH{1'b0}};
            o_out_valid <= 1'b0;
        end else if (i_clr) begin
            r_acc       <= {WIDTH{1'b0}};
            r_lfsr      <= LFSR_SEED;
            o_c_out     <= 1'b0;
            o_e_out     <= {WIDTH{1'b0}};
            o_out_valid <= 1'b0;
        end else if (i_en) begin
            r_acc       <= w_sum[WIDTH-1:0];
            o_c_out     <= w_sum[WIDTH];
            o_e_out     <= msb_flip(w_sum[WIDTH-1:0]);
            o_out_valid <= 1'b1;
            if (DITHER_EN) begin
                r_lfsr <= lfsr_next(r_lfsr);
            end else begin
                r_lfsr <= r_lfsr;
            end
        end else begin
            o_out_valid <= 1'b0;
        end
    end

    // Carry-density window: the closing sample's own carry is included.
    always_ff @(posedge i_clck or posedge i_rst) begin
        if (i_rst) begin
            r_win_cnt    <= {WIN_LOG2{1'b0}};
            r_carry_cnt  <= {(WIN_LOG2+1){1'b0}};
            o_density    <= {(WIN_LOG2+1){1'b0}};
            o_dens_valid <= 1'b0;
        end else if (i_clr) begin
            r_win_cnt    <= {WIN_LOG2{1'b0}};
            r_carry_cnt  <= {(WIN_LOG2+1){1'b0}};
            o_density    <= {(WIN_LOG2+1){1'b0}};
            o_dens_valid <= 1'b0;
        end else if (i_en) begin
            r_win_cnt <= r_win_cnt + WIN_LOG2'(1);
            if (w_win_last) begin
                o_density    <= r_carry_cnt + w_carry_ext;
                o_dens_valid <= 1'b1;
                r_carry_cnt  <= {(WIN_LOG2+1){1'b0}};
            end else begin
                o_dens_valid <= 1'b0;
                r_carry_cnt  <= r_carry_cnt + w_carry_ext;
            end
        end else begin
            o_dens_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mash_stage1_accum.sv
module tb_mash_stage1_accum;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       en;
    logic [3:0] x;

    logic       c0, v0, dv0, c1, v1, dv1;
    logic [3:0] e0, e1;
    logic [4:0] d0, d1;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mash_stage1_accum #(.WIDTH(4), .DITHER_EN(1'b0), .LFSR_SEED(8'hA5), .WIN_LOG2(4)) u_dut0 (
        .i_clck(clk), .i_rst(rst), .i_clr(clr), .i_en(en), .i_x(x),
        .o_c_out(c0), .o_e_out(e0), .o_out_valid(v0),
        .o_density(d0), .o_dens_valid(dv0));

    mash_stage1_accum #(.WIDTH(4), .DITHER_EN(1'b1), .LFSR_SEED(8'hA5), .WIN_LOG2(4)) u_dut1 (
        .i_clck(clk), .i_rst(rst), .i_clr(clr), .i_en(en), .i_x(x),
        .o_c_out(c1), .o_e_out(e1), .o_out_valid(v1),
        .o_density(d1), .o_dens_valid(dv1));

    typedef struct {
        logic       c;
        logic [3:0] e;
        logic       v;
        logic [4:0] dens;
        logic       dv;
    } exp_t;

    typedef struct {
        logic [3:0] x;
        logic       exp_c;
        logic [3:0] exp_e;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model state, index 0 = no dither, 1 = dither.
    logic [3:0] m_acc  [2];
    logic [7:0] m_lfsr [2];
    logic [3:0] m_win  [2];
    logic [4:0] m_ccnt [2];
    exp_t       m_out  [2];
    int         dsum;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_acc[k]  = 4'd0;
            m_lfsr[k] = 8'hA5;
            m_win[k]  = 4'd0;
            m_ccnt[k] = 5'd0;
            m_out[k]  = '{c: 1'b0, e: 4'd0, v: 1'b0, dens: 5'd0, dv: 1'b0};
        end
    endtask

    task automatic model_step(input int k, input logic s_en, input logic s_clr, input logic [3:0] s_x);
        logic [4:0] s;
        logic       d;
        logic [3:0] u;
        if (s_clr) begin
            m_acc[k]  = 4'd0;
            m_lfsr[k] = 8'hA5;
            m_win[k]  = 4'd0;
            m_ccnt[k] = 5'd0;
            m_out[k]  = '{c: 1'b0, e: 4'd0, v: 1'b0, dens: 5'd0, dv: 1'b0};
        end else if (s_en) begin
            d = (k == 1) ? m_lfsr[k][0] : 1'b0;
            if (k == 1) dsum += int'(d);
            u = s_x ^ 4'b1000;
            s = 5'(m_acc[k]) + 5'(u) + 5'(d);
            m_acc[k]   = s[3:0];
            m_out[k].c = s[4];
            m_out[k].e = s[3:0] ^ 4'b1000;
            m_out[k].v = 1'b1;
            if (k == 1) m_lfsr[k] = {m_lfsr[k][6:0], m_lfsr[k][7] ^ m_lfsr[k][5] ^ m_lfsr[k][4] ^ m_lfsr[k][3]};
            if (m_win[k] == 4'd15) begin
                m_out[k].dens = m_ccnt[k] + 5'(s[4]);
                m_out[k].dv   = 1'b1;
                m_ccnt[k]     = 5'd0;
            end else begin
                m_out[k].dv = 1'b0;
                m_ccnt[k]   = m_ccnt[k] + 5'(s[4]);
            end
            m_win[k] = m_win[k] + 4'd1;
        end else begin
            m_out[k].v  = 1'b0;
            m_out[k].dv = 1'b0;
        end
    endtask

    task automatic compare(input int k);
        exp_t e;
        if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
        if (k == 0) begin
            chk("d0.c_out", 32'(c0), 32'(e.c));
            chk("d0.e_out", 32'(e0), 32'(e.e));
            chk("d0.out_valid", 32'(v0), 32'(e.v));
            chk("d0.density", 32'(d0), 32'(e.dens));
            chk("d0.dens_valid", 32'(dv0), 32'(e.dv));
        end else begin
            chk("d1.c_out", 32'(c1), 32'(e.c));
            chk("d1.e_out", 32'(e1), 32'(e.e));
            chk("d1.out_valid", 32'(v1), 32'(e.v));
            chk("d1.density", 32'(d1), 32'(e.dens));
            chk("d1.dens_valid", 32'(dv1), 32'(e.dv));
        end
    endtask

    // Drive one cycle at the falling edge, predict, then compare 1 time unit after the rising edge.
    task automatic cycle(input logic s_en, input logic s_clr, input logic [3:0] s_x);
        @(negedge clk);
        en  = s_en;
        clr = s_clr;
        x   = s_x;
        for (int k = 0; k < 2; k++) model_step(k, s_en, s_clr, s_x);
        q0.push_back(m_out[0]);
        q1.push_back(m_out[1]);
        @(posedge clk);
        #1;
        compare(0);
        compare(1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".c_out"}, 32'({c0, c1}), 32'd0);
        chk({tag, ".e_out"}, 32'({e0, e1}), 32'd0);
        chk({tag, ".out_valid"}, 32'({v0, v1}), 32'd0);
        chk({tag, ".density"}, 32'({d0, d1}), 32'd0);
        chk({tag, ".dens_valid"}, 32'({dv0, dv1}), 32'd0);
    endtask

    vec_t tbl[8];
    int   pulses;
    int   carries;
    int   diff;

    initial begin
        // Hand-computed vectors for the undithered instance, starting from acc=0.
        tbl[0] = '{x: 4'h0, exp_c: 1'b0, exp_e: 4'h0};   // acc 8
        tbl[1] = '{x: 4'h0, exp_c: 1'b1, exp_e: 4'h8};   // acc 0
        tbl[2] = '{x: 4'h7, exp_c: 1'b0, exp_e: 4'h7};   // acc 15
        tbl[3] = '{x: 4'h7, exp_c: 1'b1, exp_e: 4'h6};   // acc 14
        tbl[4] = '{x: 4'h8, exp_c: 1'b0, exp_e: 4'h6};   // acc 14
        tbl[5] = '{x: 4'hF, exp_c: 1'b1, exp_e: 4'hD};   // acc 5
        tbl[6] = '{x: 4'h3, exp_c: 1'b1, exp_e: 4'h8};   // acc 0
        tbl[7] = '{x: 4'h8, exp_c: 1'b0, exp_e: 4'h8};   // acc 0

        rst = 1'b1; clr = 1'b0; en = 1'b0; x = 4'h0;
        dsum = 0;
        model_reset();
        #12;
        check_all_zero("por");
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors.
        cycle(1'b0, 1'b1, 4'h0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, tbl[i].x);
            chk($sformatf("tbl[%0d].c_out", i), 32'(c0), 32'(tbl[i].exp_c));
            chk($sformatf("tbl[%0d].e_out", i), 32'(e0), 32'(tbl[i].exp_e));
        end

        // Async reset mid-stream: outputs clear before any clock edge.
        cycle(1'b1, 1'b0, 4'h5);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        en = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // x=0 continuous: alternating carry, one density pulse of 8.
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 4'h0);
            pulses += int'(dv0);
        end
        chk("t2.pulses", 32'(pulses), 32'd1);
        chk("t2.density", 32'(d0), 32'd8);

        // x=7: first window density 15; x=-8: density 0.
        cycle(1'b0, 1'b1, 4'h0);
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 4'h7);
        chk("t3.density_max", 32'(d0), 32'd15);
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 4'h8);
        chk("t3.density_min", 32'(d0), 32'd0);

        // en gaps: outputs hold, window advances only on accepted samples.
        cycle(1'b0, 1'b1, 4'h0);
        cycle(1'b1, 1'b0, 4'h0);
        cycle(1'b0, 1'b0, 4'h0);
        cycle(1'b0, 1'b0, 4'h0);
        cycle(1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, 4'h0);
        chk("t4.window_close", 32'(dv0), 32'd1);

        // clr with en mid-window: sample discarded, restart from zero.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 4'h3);
        cycle(1'b1, 1'b1, 4'h5);
        chk("t5.cleared_valid", 32'(v0), 32'd0);
        for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 4'h0);
        chk("t5.no_early_close", 32'(dv0), 32'd0);
        cycle(1'b1, 1'b0, 4'h0);
        chk("t5.window_close", 32'(dv0), 32'd1);

        // Dithered run: LFSR sequence checked through outputs, carry count vs dither sum.
        cycle(1'b0, 1'b1, 4'h0);
        dsum    = 0;
        carries = 0;
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, 1'b0, 4'h0);
            carries += int'(c1);
        end
        diff = carries - (128 + dsum / 16);
        chk("t6.carry_density_ok", 32'((diff >= -1) && (diff <= 1)), 32'd1);

        // Random traffic through the scoreboard.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0), 4'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
